mac_pe_seq: RTL and testbench

- Sequencer for one mac_pe-style fixed→float MAC processing element.
- Per job it:
  - clears the PE accumulator by pulsing the PE reset;
  - loads the B vector into PE local RAM;
  - streams the A vector one element at a time, waiting for each accumulate to complete;
  - returns the final 32-bit fixed result on a valid/ready port.
- The PE feeds its accumulator back only after its result-valid, so elements cannot be pipelined. The sequencer guarantees this spacing.

---
 rtl/mac_pe_seq.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_mac_pe_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pe_seq.sv
// -----------------------------------------------------------------------------
// mac_pe_seq
//
// Job sequencer for a single fixed->float MAC processing element (PE).
// Each job runs through the same steps:
//   1. Clear the PE accumulator by holding pe_aresetn low for CLR_CYCLES.
//   2. Load the B vector into the PE local RAM. Each 32-bit word holds two
//      elements: [31:16] is the even element and [15:0] is the odd element.
//   3. Stream the A vector one element at a time. Each element waits for the
//      PE result-valid, because the PE only feeds its accumulator back after
//      pe_dvalid. Elements therefore cannot be pipelined.
//   4. Present the final accumulator value on a valid/ready result port.
//
// Ports
//   aclk, aresetn        clock; synchronous active-low reset
//   start, vec_len       job start pulse (IDLE only) and element count
//   s_bvalid/s_bdata/s_bready   B word stream (two elements per word)
//   s_avalid/s_adata/s_aready   A element stream
//   m_valid/m_result/m_ready    result port; held until m_ready
//   busy                 high in every state except IDLE
//   err                  sticky: bad length or PE timeout; cleared by the
//                        next accepted start
//   pe_aresetn           PE reset; low under aresetn and during CLEAR
//   pe_we/pe_addr/pe_din PE RAM write port (addr = word index on writes,
//                        element index on reads)
//   pe_ain/pe_valid      PE A operand and one-cycle issue pulse
//   pe_dvalid/pe_dout    PE result
//
// Every output is a flop. The _d values are computed in a single always_comb
// and registered in a single always_ff.
// -----------------------------------------------------------------------------
module mac_pe_seq #(
  parameter int L_RAM_SIZE   = 6,
  parameter int CLR_CYCLES   = 4,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [L_RAM_SIZE:0]   vec_len,
  input  logic                  s_bvalid,
  input  logic [31:0]           s_bdata,
  output logic                  s_bready,
  input  logic                  s_avalid,
  input  logic [15:0]           s_adata,
  output logic                  s_aready,
  output logic                  m_valid,
  output logic [31:0]           m_result,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  err,
  output logic                  pe_aresetn,
  output logic                  pe_we,
  output logic [L_RAM_SIZE-1:0] pe_addr,
  output logic [31:0]           pe_din,
  output logic [15:0]           pe_ain,
  output logic                  pe_valid,
  input  logic                  pe_dvalid,
  input  logic [31:0]           pe_dout
);

  localparam int LEN_W = L_RAM_SIZE + 1;
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam int TMR_W = $clog2(WAIT_TIMEOUT + 1);

  // Largest legal job length, 2**L_RAM_SIZE, in the width of vec_len.
  localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {L_RAM_SIZE{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RD,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [CLR_W-1:0]        clr_q, clr_d;
  logic [L_RAM_SIZE-1:0]   w_q, w_d;      // B word index
  logic [L_RAM_SIZE-1:0]   e_q, e_d;      // A/B element index
  logic [TMR_W-1:0]        tmr_q, tmr_d;  // per-element wait timer

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  logic                  s_bready_q, s_bready_d;
  logic                  s_aready_q, s_aready_d;
  logic                  m_valid_q, m_valid_d;
  logic [31:0]           m_result_q, m_result_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  pe_aresetn_q, pe_aresetn_d;
  logic                  pe_we_q, pe_we_d;
  logic [L_RAM_SIZE-1:0] pe_addr_q, pe_addr_d;
  logic [31:0]           pe_din_q, pe_din_d;
  logic [15:0]           pe_ain_q, pe_ain_d;
  logic                  pe_valid_q, pe_valid_d;

  // len-1 gives both terminal indices. The element index is the low bits.
  // The word index is the same value halved, so an odd length ends on a
  // word whose low half is never read.
  logic [LEN_W-1:0]      len_m1;
  logic [L_RAM_SIZE-1:0] last_elem;
  logic [L_RAM_SIZE-1:0] last_word;

  assign len_m1    = len_q - LEN_W'(1);
  assign last_elem = len_m1[L_RAM_SIZE-1:0];
  assign last_word = len_m1[L_RAM_SIZE:1];

  logic len_bad;
  assign len_bad = (vec_len == '0) || (vec_len > MAX_LEN);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    clr_d      = clr_q;
    w_d        = w_q;
    e_d        = e_q;
    tmr_d      = tmr_q;
    m_valid_d  = m_valid_q;
    m_result_d = m_result_q;
    err_d      = err_q;
    pe_addr_d  = pe_addr_q;
    pe_din_d   = pe_din_q;
    pe_ain_d   = pe_ain_q;
    // Write enable and issue are single-cycle pulses.
    pe_we_d    = 1'b0;
    pe_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_bad) begin
            err_d = 1'b1;
          end else begin
            len_d   = vec_len;
            err_d   = 1'b0;
            clr_d   = '0;
            w_d     = '0;
            e_d     = '0;
            state_d = S_CLEAR;
          end
        end
      end

      S_CLEAR: begin
        // pe_aresetn went low on the edge that entered CLEAR. It is held
        // low through CLR_CYCLES edges in total, counting that entry edge.
        if (clr_q == CLR_W'(CLR_CYCLES - 1)) begin
          state_d = S_LOAD;
        end else begin
          clr_d = clr_q + CLR_W'(1);
        end
      end

      S_LOAD: begin
        if (s_bvalid && s_bready_q) begin
          pe_we_d   = 1'b1;
          pe_addr_d = w_q;
          pe_din_d  = s_bdata;
          w_d       = w_q + L_RAM_SIZE'(1);
          if (w_q == last_word) begin
            state_d = S_RD;
          end
        end
      end

      S_RD: begin
        // Point the RAM at the element before the A operand is taken. This
        // covers the PE's one-cycle read latency. The last B write, if any,
        // is on the bus during this cycle.
        pe_addr_d = e_q;
        state_d   = S_ISSUE;
      end

      S_ISSUE: begin
        if (s_avalid && s_aready_q) begin
          pe_ain_d   = s_adata;
          pe_valid_d = 1'b1;
          tmr_d      = '0;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (pe_dvalid) begin
          if (e_q == last_elem) begin
            m_result_d = pe_dout;
            m_valid_d  = 1'b1;
            state_d    = S_RESP;
          end else begin
            e_d       = e_q + L_RAM_SIZE'(1);
            pe_addr_d = e_q + L_RAM_SIZE'(1);
            state_d   = S_RD;
          end
        end else if (tmr_q == TMR_W'(WAIT_TIMEOUT - 1)) begin
          // The abort lands WAIT_TIMEOUT cycles after the pe_valid pulse.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_RESP: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs that depend only on the state are derived from the next state.
    // This keeps them registered and aligned with the state they describe.
    busy_d       = (state_d != S_IDLE);
    s_bready_d   = (state_d == S_LOAD);
    s_aready_d   = (state_d == S_ISSUE);
    pe_aresetn_d = (state_d != S_CLEAR);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      clr_q        <= '0;
      w_q          <= '0;
      e_q          <= '0;
      tmr_q        <= '0;
      s_bready_q   <= 1'b0;
      s_aready_q   <= 1'b0;
      m_valid_q    <= 1'b0;
      m_result_q   <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      pe_aresetn_q <= 1'b0;
      pe_we_q      <= 1'b0;
      pe_addr_q    <= '0;
      pe_din_q     <= '0;
      pe_ain_q     <= '0;
      pe_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      clr_q        <= clr_d;
      w_q          <= w_d;
      e_q          <= e_d;
      tmr_q        <= tmr_d;
      s_bready_q   <= s_bready_d;
      s_aready_q   <= s_aready_d;
      m_valid_q    <= m_valid_d;
      m_result_q   <= m_result_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      pe_aresetn_q <= pe_aresetn_d;
      pe_we_q      <= pe_we_d;
      pe_addr_q    <= pe_addr_d;
      pe_din_q     <= pe_din_d;
      pe_ain_q     <= pe_ain_d;
      pe_valid_q   <= pe_valid_d;
    end
  end

  assign s_bready   = s_bready_q;
  assign s_aready   = s_aready_q;
  assign m_valid    = m_valid_q;
  assign m_result   = m_result_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign pe_aresetn = pe_aresetn_q;
  assign pe_we      = pe_we_q;
  assign pe_addr    = pe_addr_q;
  assign pe_din     = pe_din_q;
  assign pe_ain     = pe_ain_q;
  assign pe_valid   = pe_valid_q;

endmodule

// File: tb/tb_mac_pe_seq.sv
// Bench for mac_pe_seq. A small PE model sits behind the sequencer. The PE
// RAM has a registered read and the accumulator sums pe_ain*B with a fixed
// latency. Expected results are queued when each job is issued. A negedge
// monitor pops them when m_valid && m_ready.
module tb_mac_pe_seq;
  localparam int L      = 6;
  localparam int CLR    = 4;
  localparam int TMO    = 255;
  localparam int PE_LAT = 3;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         start = 1'b0;
  logic [L:0]   vec_len = '0;
  logic         s_bvalid = 1'b0;
  logic [31:0]  s_bdata = '0;
  logic         s_bready;
  logic         s_avalid = 1'b0;
  logic [15:0]  s_adata = '0;
  logic         s_aready;
  logic         m_valid;
  logic [31:0]  m_result;
  logic         m_ready = 1'b0;
  logic         busy, err, pe_aresetn, pe_we, pe_valid;
  logic [L-1:0] pe_addr;
  logic [31:0]  pe_din;
  logic [15:0]  pe_ain;
  logic         pe_dvalid;
  logic [31:0]  pe_dout;

  mac_pe_seq #(.L_RAM_SIZE(L), .CLR_CYCLES(CLR), .WAIT_TIMEOUT(TMO)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .vec_len(vec_len),
    .s_bvalid(s_bvalid), .s_bdata(s_bdata), .s_bready(s_bready),
    .s_avalid(s_avalid), .s_adata(s_adata), .s_aready(s_aready),
    .m_valid(m_valid), .m_result(m_result), .m_ready(m_ready),
    .busy(busy), .err(err), .pe_aresetn(pe_aresetn), .pe_we(pe_we),
    .pe_addr(pe_addr), .pe_din(pe_din), .pe_ain(pe_ain), .pe_valid(pe_valid),
    .pe_dvalid(pe_dvalid), .pe_dout(pe_dout)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- PE model ----------------
  logic [31:0]        pe_mem [0:63];
  logic [15:0]        b_rd = '0;
  logic signed [31:0] acc = '0;
  int                 lat = 0;
  bit                 dv_en = 1'b1;

  function automatic logic [15:0] elem(input logic [L-1:0] a);
    logic [31:0] w;
    w = pe_mem[a >> 1];
    return a[0] ? w[15:0] : w[31:16];
  endfunction

  always @(posedge aclk) begin
    b_rd <= elem(pe_addr);
    if (pe_we) pe_mem[pe_addr] <= pe_din;
    if (!pe_aresetn) begin
      acc <= '0; lat <= 0; pe_dvalid <= 1'b0;
    end else begin
      pe_dvalid <= 1'b0;
      if (pe_valid) begin
        acc <= acc + $signed(pe_ain) * $signed(b_rd);
        lat <= PE_LAT;
      end else if (lat > 0) begin
        lat <= lat - 1;
        if (lat == 1 && dv_en) pe_dvalid <= 1'b1;
      end
    end
  end
  assign pe_dout = acc;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- Monitor / scoreboard ----------------
  logic [31:0]  exp_q[$];
  int           wr_addr_q[$];
  logic [31:0]  wr_data_q[$];
  int           clr_run = 0, last_clr = 0, elem_idx = 0;
  int           last_valid_cyc = 0, err_rise_cyc = 0;
  bit           outstanding = 1'b0, err_prev = 1'b0;
  logic [L-1:0] prev_addr = '0;

  initial forever begin
    @(negedge aclk);
    if (aresetn && !pe_aresetn) clr_run++;
    else if (pe_aresetn && clr_run > 0) begin last_clr = clr_run; clr_run = 0; end
    if (pe_we) begin wr_addr_q.push_back(int'(pe_addr)); wr_data_q.push_back(pe_din); end
    if (!pe_aresetn) begin
      outstanding = 1'b0; elem_idx = 0;
    end else begin
      if (pe_dvalid) outstanding = 1'b0;
      if (pe_valid) begin
        check_eq("pe_valid before prior pe_dvalid", 32'(outstanding), 32'd0);
        check_eq("pe_addr one cycle before pe_valid", 32'(prev_addr), elem_idx);
        elem_idx++;
        outstanding = 1'b1;
        last_valid_cyc = cyc;
      end
    end
    if (err && !err_prev) err_rise_cyc = cyc;
    err_prev = err;
    prev_addr = pe_addr;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) check_eq("unexpected result", m_result, 32'hDEADBEEF);
      else check_eq("m_result", m_result, exp_q.pop_front());
    end
  end

  // ---------------- Drivers ----------------
  int          bw [0:31];
  logic [15:0] av [0:63];

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic send_b(input logic [31:0] w);
    int t = 0;
    s_bvalid = 1'b1; s_bdata = w;
    @(negedge aclk);
    while (!s_bready && t < 300) begin @(negedge aclk); t++; end
    check_eq("s_bready before timeout", 32'(s_bready), 32'd1);
    tick();
    s_bvalid = 1'b0;
  endtask

  task automatic send_a(input logic [15:0] a, input int gap, input bit chk_stall);
    int t = 0;
    s_avalid = 1'b0;
    repeat (gap) tick();
    if (chk_stall) check_eq("stall in ISSUE with pe_valid low", {30'd0, s_aready, pe_valid}, 32'd2);
    s_avalid = 1'b1; s_adata = a;
    @(negedge aclk);
    while (!s_aready && t < 600) begin @(negedge aclk); t++; end
    check_eq("s_aready before timeout", 32'(s_aready), 32'd1);
    tick();
    s_avalid = 1'b0;
  endtask

  task automatic resp(input int hold, input bit rs);
    int t = 0;
    logic [31:0] held;
    bit stable = 1'b1;
    while (!m_valid && t < 3000) begin @(negedge aclk); t++; end
    check_eq("m_valid arrives", 32'(m_valid), 32'd1);
    held = m_result;
    for (int i = 0; i < hold; i++) begin
      tick();
      start = rs && (i == 4);
      if (rs && i == 4) vec_len = 7'd2;
      @(negedge aclk);
      if (!m_valid || m_result !== held) stable = 1'b0;
    end
    if (hold > 0) check_eq("m_valid/m_result held while m_ready low", 32'(stable), 32'd1);
    tick();
    start = 1'b0; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic run_job(input int len, input int gap, input int hold, input bit rs,
                         input logic [31:0] expv);
    int nw;
    nw = (len + 1) / 2;
    exp_q.push_back(expv);
    wr_addr_q.delete(); wr_data_q.delete();
    start = 1'b1; vec_len = 7'(len);
    tick();
    start = 1'b0;
    check_eq("busy after start", 32'(busy), 32'd1);
    check_eq("err cleared by start", 32'(err), 32'd0);
    fork
      begin for (int i = 0; i < nw; i++) send_b(bw[i]); end
      begin for (int i = 0; i < len; i++) send_a(av[i], gap, (gap >= 8) && (i > 0)); end
      begin resp(hold, rs); end
    join
    tick(); tick();
    check_eq("busy after job", 32'(busy), 32'd0);
    check_eq("pe_aresetn low cycles", last_clr, CLR);
    check_eq("B write count", wr_addr_q.size(), nw);
    for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
      check_eq("B write addr", wr_addr_q[i], i);
      check_eq("B write data", wr_data_q[i], bw[i]);
    end
    check_eq("pe_valid pulses", elem_idx, len);
    check_eq("scoreboard drained", exp_q.size(), 0);
  endtask

  task automatic bad_start(input int len);
    bit ok = 1'b1;
    start = 1'b1; vec_len = 7'(len);
    tick();
    start = 1'b0;
    check_eq("err on illegal len", 32'(err), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (busy || s_bready) ok = 1'b0;
      tick();
    end
    check_eq("illegal start ignored", 32'(ok), 32'd1);
  endtask

  function automatic bit outs_zero();
    return ({s_bready, s_aready, m_valid, m_result, busy, err, pe_aresetn,
             pe_we, pe_addr, pe_din, pe_ain, pe_valid} == '0);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    aresetn = 1'b0;
    repeat (3) tick();
    check_eq("reset outputs zero", 32'(outs_zero()), 32'd1);
    aresetn = 1'b1;
    tick(); tick();
    check_eq("idle pe_aresetn high", {30'd0, pe_aresetn, busy}, 32'd2);

    // len=4: 1,2,3,4 dot 1,1,1,1 = 10
    bw[0] = 32'h0001_0002; bw[1] = 32'h0003_0004;
    av[0] = 16'd1; av[1] = 16'd1; av[2] = 16'd1; av[3] = 16'd1;
    run_job(4, 0, 0, 1'b0, 32'd10);

    bad_start(0);

    // len=3 odd: 5,6,7 dot 2,3,4 = 56; low half of word 1 is unused
    bw[0] = 32'h0005_0006; bw[1] = 32'h0007_FFFF;
    av[0] = 16'd2; av[1] = 16'd3; av[2] = 16'd4;
    run_job(3, 8, 10, 1'b1, 32'd56);

    bad_start(65);

    // len=2 signed: 2,3 dot -1,5 = 13
    bw[0] = 32'h0002_0003;
    av[0] = 16'hFFFF; av[1] = 16'd5;
    run_job(2, 0, 0, 1'b0, 32'd13);

    // PE timeout: no pe_dvalid ever
    dv_en = 1'b0;
    start = 1'b1; vec_len = 7'd1;
    tick();
    start = 1'b0;
    send_b(32'h0001_0000);
    send_a(16'd1, 0, 1'b0);
    t = 0;
    while (!err && t < 400) begin @(negedge aclk); t++; end
    tick();
    check_eq("timeout latency", err_rise_cyc - last_valid_cyc, TMO);
    check_eq("timeout idle no result", {30'd0, busy, m_valid}, 32'd0);
    check_eq("timeout err", 32'(err), 32'd1);
    dv_en = 1'b1;

    // Reset while in WAIT
    start = 1'b1; vec_len = 7'd2;
    tick();
    start = 1'b0;
    send_b(32'h0002_0003);
    send_a(16'd1, 0, 1'b0);
    tick();
    check_eq("in WAIT before reset", {30'd0, busy, s_aready}, 32'd2);
    aresetn = 1'b0;
    tick();
    check_eq("reset in WAIT outputs zero", 32'(outs_zero()), 32'd1);
    aresetn = 1'b1;
    tick(); tick();

    // len=2 after reset: 7,8 dot 1,2 = 23
    bw[0] = 32'h0007_0008;
    av[0] = 16'd1; av[1] = 16'd2;
    run_job(2, 0, 0, 1'b0, 32'd23);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
